// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and CMP result bit positions shared by the ALU and its users
package alu_pkg;
    localparam logic [4:0] OP_PASS = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_SUB  = 5'd5;
    localparam logic [4:0] OP_MUL  = 5'd6;
    localparam logic [4:0] OP_DIV  = 5'd7;
    localparam logic [4:0] OP_AND  = 5'd8;
    localparam logic [4:0] OP_NAND = 5'd9;
    localparam logic [4:0] OP_OR   = 5'd10;
    localparam logic [4:0] OP_XOR  = 5'd11;
    localparam logic [4:0] OP_CMP  = 5'd12;
    localparam logic [4:0] OP_NOT  = 5'd13;
    localparam logic [4:0] OP_SHL  = 5'd14;
    localparam logic [4:0] OP_SHR  = 5'd15;
    localparam int CMP_EQ_BIT = 0;
    localparam int CMP_LT_BIT = 1;
endpackage

// File: rtl/alu.sv
// alu: unsigned single-cycle ALU, combinational op select into one output register
// Ports: clk, rst (async, active-high), operand_a/operand_b (data), op_code (5-bit select),
//        result (registered), zero (result == 0), div_by_zero (DIV with operand_b == 0)
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH_DATA = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_DATA-1:0] operand_a,
    input  logic [WIDTH_DATA-1:0] operand_b,
    input  logic [4:0]            op_code,
    output logic [WIDTH_DATA-1:0] result,
    output logic                  zero,
    output logic                  div_by_zero
);
    logic [WIDTH_DATA-1:0] w_res;
    logic                  w_dbz;
    logic [WIDTH_DATA-1:0] r_result;
    logic                  r_zero;
    logic                  r_dbz;
    always_comb begin
        w_res = '0;
        w_dbz = 1'b0;
        case (op_code)
            OP_PASS: w_res = operand_a;
            OP_ADD:  w_res = operand_a + operand_b;
            OP_SUB:  w_res = operand_a - operand_b;
            OP_MUL:  w_res = operand_a * operand_b;
            OP_DIV: begin
                w_dbz = (operand_b == '0);
                w_res = w_dbz ? '1 : operand_a / operand_b;
            end
            OP_AND:  w_res = operand_a & operand_b;
            OP_NAND: w_res = ~(operand_a & operand_b);
            OP_OR:   w_res = operand_a | operand_b;
            OP_XOR:  w_res = operand_a ^ operand_b;
            OP_CMP: begin
                w_res[CMP_EQ_BIT] = (operand_a == operand_b);
                w_res[CMP_LT_BIT] = (operand_a < operand_b);
            end
            OP_NOT:  w_res = ~operand_a;
            OP_SHL:  w_res = operand_a << operand_b[4:0];
            OP_SHR:  w_res = operand_a >> operand_b[4:0];
            default: w_res = '0;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_dbz    <= 1'b0;
        end else begin
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_dbz    <= w_dbz;
        end
    end
    assign result      = r_result;
    assign zero        = r_zero;
    assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for alu with a behavioural reference model and per-cycle compare
module tb_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  op = '0;
    logic [31:0] result;
    logic        zero;
    logic        div_by_zero;
    int n_cmp = 0;
    int n_bad = 0;
    logic        have_exp = 1'b0;
    logic [32:0] exp_v;

    alu #(.WIDTH_DATA(32)) dut (
        .clk(clk), .rst(rst), .operand_a(a), .operand_b(b), .op_code(op),
        .result(result), .zero(zero), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Returns {div_by_zero, result} using 64-bit arithmetic reduced modulo 2^32
    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y, input logic [4:0] o);
        longint unsigned xl = 64'(x);
        longint unsigned yl = 64'(y);
        longint unsigned m = 64'h1_0000_0000;
        longint unsigned r = 0;
        logic d = 1'b0;
        case (o)
            5'd0:  r = xl;
            5'd4:  r = (xl + yl) % m;
            5'd5:  r = (xl + m - yl) % m;
            5'd6:  r = (xl * yl) % m;
            5'd7:  if (yl == 0) begin r = m - 1; d = 1'b1; end else r = xl / yl;
            5'd8:  r = xl & yl;
            5'd9:  r = (m - 1) - (xl & yl);
            5'd10: r = xl | yl;
            5'd11: r = xl ^ yl;
            5'd12: r = (xl == yl) ? 1 : (xl < yl) ? 2 : 0;
            5'd13: r = (m - 1) - xl;
            5'd14: r = (xl << y[4:0]) % m;
            5'd15: r = xl >> y[4:0];
            default: r = 0;
        endcase
        return {d, r[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) have_exp <= 1'b0;
        else begin
            exp_v    <= model(a, b, op);
            have_exp <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst && have_exp) begin
            chk("model.result", result, exp_v[31:0]);
            chk("model.zero", {31'd0, zero}, {31'd0, exp_v[31:0] == 32'd0});
            chk("model.dbz", {31'd0, div_by_zero}, {31'd0, exp_v[32]});
        end
    end

    task automatic vec(input logic [31:0] va, input logic [31:0] vb, input logic [4:0] vo,
                       input logic [31:0] er, input logic ez, input logic ed);
        logic [32:0] mv;
        @(negedge clk);
        a = va; b = vb; op = vo;
        mv = model(va, vb, vo);
        chk($sformatf("pin.op%0d", vo), mv[31:0], er);
        @(posedge clk);
        #1;
        chk($sformatf("lit.op%0d.result", vo), result, er);
        chk($sformatf("lit.op%0d.zero", vo), {31'd0, zero}, {31'd0, ez});
        chk($sformatf("lit.op%0d.dbz", vo), {31'd0, div_by_zero}, {31'd0, ed});
    endtask

    initial begin
        #12;
        chk("reset.result", result, 32'd0);
        chk("reset.zero", {31'd0, zero}, 32'd1);
        chk("reset.dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        a = 32'd10; b = 32'd20; op = 5'd4;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_after_reset", result, 32'd30);
        vec(32'd10, 32'd20, 5'd4, 32'd30, 1'b0, 1'b0);
        vec(32'd30, 32'd20, 5'd5, 32'd10, 1'b0, 1'b0);
        vec(32'd3, 32'd4, 5'd6, 32'd12, 1'b0, 1'b0);
        vec(32'd40, 32'd4, 5'd7, 32'd10, 1'b0, 1'b0);
        vec(32'd40, 32'd0, 5'd7, 32'hFFFFFFFF, 1'b0, 1'b1);
        vec(32'd1, 32'd0, 5'd8, 32'd0, 1'b1, 1'b0);
        vec(32'd1, 32'd0, 5'd9, 32'hFFFFFFFF, 1'b0, 1'b0);
        vec(32'd1, 32'd1, 5'd10, 32'd1, 1'b0, 1'b0);
        vec(32'd1, 32'd1, 5'd13, 32'hFFFFFFFE, 1'b0, 1'b0);
        vec(32'd10, 32'd10, 5'd12, 32'd1, 1'b0, 1'b0);
        vec(32'd5, 32'd9, 5'd12, 32'd2, 1'b0, 1'b0);
        vec(32'd9, 32'd5, 5'd12, 32'd0, 1'b1, 1'b0);
        vec(32'hFFFFFFFF, 32'd1, 5'd4, 32'd0, 1'b1, 1'b0);
        vec(32'd0, 32'd1, 5'd5, 32'hFFFFFFFF, 1'b0, 1'b0);
        vec(32'd0, 32'd1, 5'd20, 32'd0, 1'b1, 1'b0);
        vec(32'h0000F0F0, 32'h00000FF0, 5'd11, 32'h0000FF00, 1'b0, 1'b0);
        vec(32'h80000001, 32'd33, 5'd14, 32'h00000002, 1'b0, 1'b0);
        vec(32'h80000000, 32'd31, 5'd15, 32'd1, 1'b0, 1'b0);
        vec(32'h12345678, 32'd9, 5'd0, 32'h12345678, 1'b0, 1'b0);
        vec(32'h10000, 32'h10000, 5'd6, 32'd0, 1'b1, 1'b0);
        vec(32'd7, 32'd0, 5'd2, 32'd0, 1'b1, 1'b0);
        vec(32'd7, 32'd0, 5'd31, 32'd0, 1'b1, 1'b0);
        vec(32'd40, 32'd0, 5'd7, 32'hFFFFFFFF, 1'b0, 1'b1);
        vec(32'd40, 32'd0, 5'd4, 32'd40, 1'b0, 1'b0);
        vec(32'd5, 32'd6, 5'd4, 32'd11, 1'b0, 1'b0);
        @(negedge clk);
        a = 32'd7; b = 32'd8; op = 5'd4;
        #2 rst = 1'b1;
        #1;
        chk("async_reset.result", result, 32'd0);
        chk("async_reset.zero", {31'd0, zero}, 32'd1);
        chk("async_reset.dbz", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk);
        #1;
        chk("held_reset.result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_release.result", result, 32'd15);
        chk("post_release.zero", {31'd0, zero}, 32'd0);
        vec(32'd100, 32'd7, 5'd7, 32'd14, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The module SHALL have parameter WIDTH_DATA, default 32, the data width of operands and result.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The module SHALL have port operand_a, input, WIDTH_DATA bits, first operand.
REQ-005 The module SHALL have port operand_b, input, WIDTH_DATA bits, second operand.
REQ-006 The module SHALL have port op_code, input, 5 bits, operation select.
REQ-007 The module SHALL have port result, output, WIDTH_DATA bits, registered operation result.
REQ-008 The module SHALL have port zero, output, 1 bit, set when the registered result is all zeros.
REQ-009 The module SHALL have port div_by_zero, output, 1 bit, set when the registered result came from DIV with operand_b = 0.

Function
REQ-010 Operands SHALL be treated as unsigned; all arithmetic SHALL wrap modulo 2^WIDTH_DATA.
REQ-011 op_code 4 (ADD) SHALL produce a + b, with the carry discarded.
REQ-012 op_code 5 (SUB) SHALL produce a - b in two's complement, so 0 - 1 gives all ones.
REQ-013 op_code 6 (MUL) SHALL produce the low WIDTH_DATA bits of a * b.
REQ-014 op_code 7 (DIV) SHALL produce floor(a / b); for b = 0 it SHALL produce all ones and assert div_by_zero.
REQ-015 op_code 8 (AND) SHALL produce the bitwise a & b.
REQ-016 op_code 9 (NAND) SHALL produce the bitwise ~(a & b).
REQ-017 op_code 10 (OR) SHALL produce the bitwise a | b.
REQ-018 op_code 11 (XOR) SHALL produce the bitwise a ^ b.
REQ-019 op_code 12 (CMP) SHALL produce a value that is zero except bit0 = (a == b) and bit1 = (a < b), unsigned.
REQ-020 op_code 13 (NOT) SHALL produce the bitwise ~a; operand_b is ignored.
REQ-021 op_code 14 (SHL) SHALL produce a << b[4:0].
REQ-022 op_code 15 (SHR) SHALL produce the logical shift a >> b[4:0].
REQ-023 op_code 0 (PASS) SHALL produce a.
REQ-024 Every other op_code (1-3, 16-31) SHALL produce 0 with div_by_zero = 0.
REQ-025 Latency SHALL be exactly one cycle: result, zero and div_by_zero reflect the inputs sampled at the previous rising clk edge.
REQ-026 The module SHALL accept a new operation every cycle; there is no handshake and no stall.
REQ-027 zero SHALL be derived from the same value that is registered into result, in the same cycle.
REQ-028 div_by_zero SHALL be 0 for every op_code other than 7.

Reset
REQ-029 While rst = 1, result SHALL be 0, zero SHALL be 1 and div_by_zero SHALL be 0, independent of clk.
REQ-030 After rst is deasserted, the first rising edge SHALL register the current inputs normally.
REQ-031 Asserting rst during operation SHALL clear the outputs immediately, discarding the pending result.

Structure
REQ-032 A shared package alu_pkg SHALL hold the 5-bit opcode constants (OP_PASS = 0, OP_ADD = 4 through OP_SHR = 15) and the CMP bit positions.
REQ-033 The implementation SHALL be a combinational operation selector feeding one output register stage.
REQ-034 The implementation SHALL be a single module with no sub-module.

Verification
REQ-035 Bench SHALL drive a = 10, b = 20, op 4 -> result 30 one cycle later, zero = 0; and a = 30, b = 20, op 5 -> 10.
REQ-036 Bench SHALL drive a = 3, b = 4, op 6 -> 12; a = 40, b = 4, op 7 -> 10; a = 40, b = 0, op 7 -> 0xFFFFFFFF with div_by_zero = 1.
REQ-037 Bench SHALL drive a = 1, b = 0: op 8 -> 0 with zero = 1; op 9 -> 0xFFFFFFFF. Then a = 1, b = 1: op 10 -> 1; op 13 -> 0xFFFFFFFE.
REQ-038 Bench SHALL drive a = 10, b = 10, op 12 -> 1; a = 5, b = 9, op 12 -> 2; a = 9, b = 5, op 12 -> 0.
REQ-039 Bench SHALL check wrap-around: a = 0xFFFFFFFF, b = 1, op 4 -> 0 with zero = 1; a = 0, b = 1, op 5 -> 0xFFFFFFFF; op 20 -> 0.
REQ-040 Bench SHALL assert rst asynchronously mid-stream with op 4 active -> outputs 0 / zero = 1 / div_by_zero = 0 before the next clk edge; the first edge after release registers a valid result.
